// File: rtl/uart_mmio.sv
// uart_mmio - memory-mapped UART responder for the MEM-stage data bus.
//
// Register window (word aligned, addr[1:0] ignored):
//   0x4000_0018 TXD  W : wdata[7:0] starts a frame when TX is idle, else dropped
//   0x4000_001C RXD  R : {24'b0, rx_byte}; a read clears RXFULL
//   0x4000_0020 CON RW : [0] TXIE  [1] RXIE  [2] RXFULL  [3] TXDONE
//                        [4] TXBUSY  [5] OVERRUN  [6] PERR (parity build only)
//
// Ports:
//   clk       core clock, rising edge
//   reset_b   synchronous reset, active high
//   addr      byte address from the MEM stage
//   wdata     store data
//   MemRead   load strobe (one cycle per access)
//   MemWrite  store strobe (one cycle per access); wins if both strobes are high
//   rdata     combinational load data, 0 outside the window
//   irq       registered level interrupt request
//   uart_rx   asynchronous serial input, idle high
//   uart_tx   registered serial output, idle high
//
// Build option: define UART_PARITY_EN for 8E1 frames (even parity bit after
// data bit 7, checked on receive, CON bit6 = PERR). Default build is 8N1.
//
// Bus handshake: an access is a single-cycle strobe with no ready/stall; the
// block always accepts, and load data is valid in the same cycle as MemRead.

module uart_mmio #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rdata,
    output logic        irq,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif

    // ---------------- bus decode ----------------
    logic sel_txd, sel_rxd, sel_con;
    logic txd_wr, con_wr, rxd_rd, con_rd;

    assign sel_txd = (addr[31:2] == 30'h1000_0006);
    assign sel_rxd = (addr[31:2] == 30'h1000_0007);
    assign sel_con = (addr[31:2] == 30'h1000_0008);
    assign txd_wr  = MemWrite & sel_txd;
    assign con_wr  = MemWrite & sel_con;
    // A simultaneous write suppresses read side effects.
    assign rxd_rd  = MemRead & ~MemWrite & sel_rxd;
    assign con_rd  = MemRead & ~MemWrite & sel_con;

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata[31:8]};

    // ---------------- state ----------------
    logic [2:0]    tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_idx_q, tx_idx_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_line;
    logic          tx_done_set;

    logic          sync1_q, sync2_q;
    logic [2:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_idx_q, rx_idx_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_load, rx_perr_set;

    logic txie_q, txie_d, rxie_q, rxie_d;
    logic rxfull_q, rxfull_d, txdone_q, txdone_d, overrun_q, overrun_d;
    logic irq_q, irq_d;
    logic perr_bit;

`ifdef UART_PARITY_EN
    logic tx_par_q, tx_par_d;
    logic rx_par_q, rx_par_d;
    logic perr_q, perr_d;
`endif

    // ---------------- TX FSM ----------------
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_idx_d    = tx_idx_q;
        tx_shift_d  = tx_shift_q;
        tx_done_set = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d    = tx_par_q;
`endif
        case (tx_state_q)
            ST_IDLE: begin
                if (txd_wr) begin
                    tx_state_d = ST_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = wdata[7:0];
`ifdef UART_PARITY_EN
                    tx_par_d   = ^wdata[7:0];
`endif
                end
            end
            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = 3'd0;
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_d = ST_PARITY;
`else
                        tx_state_d = ST_STOP;
`endif
                    end else begin
                        tx_idx_d   = tx_idx_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d    = '0;
                    tx_state_d  = ST_IDLE;
                    tx_done_set = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    // Line level for the current state; registered so uart_tx is glitch-free
    // and trails the state by one cycle.
    always_comb begin
        tx_line = 1'b1;
        case (tx_state_q)
            ST_START:  tx_line = 1'b0;
            ST_DATA:   tx_line = tx_shift_q[0];
`ifdef UART_PARITY_EN
            ST_PARITY: tx_line = tx_par_q;
`endif
            default:   tx_line = 1'b1;
        endcase
    end

    // ---------------- RX FSM ----------------
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_idx_d    = rx_idx_q;
        rx_shift_d  = rx_shift_q;
        rx_load     = 1'b0;
        rx_perr_set = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_d    = rx_par_q;
`endif
        case (rx_state_q)
            ST_IDLE: begin
                if (!sync2_q) begin
                    rx_state_d = ST_START;
                    rx_cnt_d   = '0;
                end
            end
            ST_START: begin
                // Mid-bit re-check rejects glitches shorter than half a bit.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_idx_d = 3'd0;
                    rx_state_d = sync2_q ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                    if (rx_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_d = ST_PARITY;
`else
                        rx_state_d = ST_STOP;
`endif
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = sync2_q;
                    rx_state_d = ST_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_IDLE;
                    if (sync2_q) begin
`ifdef UART_PARITY_EN
                        if ((^rx_shift_q) == rx_par_q) rx_load = 1'b1;
                        else                           rx_perr_set = 1'b1;
`else
                        rx_load = 1'b1;
`endif
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // ---------------- flags ----------------
    // Set events win over same-cycle read clears.
    always_comb begin
        txie_d    = con_wr ? wdata[0] : txie_q;
        rxie_d    = con_wr ? wdata[1] : rxie_q;
        rx_byte_d = rx_load ? rx_shift_q : rx_byte_q;
        rxfull_d  = rx_load ? 1'b1 : (rxd_rd ? 1'b0 : rxfull_q);
        // A byte read in the same cycle as a new arrival is not an overrun.
        overrun_d = (rx_load & rxfull_q & ~rxd_rd) ? 1'b1 :
                    (con_rd ? 1'b0 : overrun_q);
        txdone_d  = tx_done_set ? 1'b1 : (con_rd ? 1'b0 : txdone_q);
        irq_d     = (txie_d & txdone_d) | (rxie_d & rxfull_d);
`ifdef UART_PARITY_EN
        perr_d    = rx_perr_set ? 1'b1 : (con_rd ? 1'b0 : perr_q);
`endif
    end

`ifdef UART_PARITY_EN
    assign perr_bit = perr_q;
`else
    assign perr_bit = 1'b0 & rx_perr_set;
`endif

    always_comb begin
        rdata = 32'h0;
        if (sel_rxd) rdata = {24'h0, rx_byte_q};
        else if (sel_con)
            rdata = {25'h0, perr_bit, overrun_q, (tx_state_q != ST_IDLE),
                     txdone_q, rxfull_q, rxie_q, txie_q};
    end

    assign irq     = irq_q;
    assign uart_tx = tx_q;

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (reset_b) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= 3'd0;
            tx_shift_q <= 8'h0;
            tx_q       <= 1'b1;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= 3'd0;
            rx_shift_q <= 8'h0;
            rx_byte_q  <= 8'h0;
            txie_q     <= 1'b0;
            rxie_q     <= 1'b0;
            rxfull_q   <= 1'b0;
            txdone_q   <= 1'b0;
            overrun_q  <= 1'b0;
            irq_q      <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
            rx_par_q   <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_line;
            sync1_q    <= uart_rx;
            sync2_q    <= sync1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            txie_q     <= txie_d;
            rxie_q     <= rxie_d;
            rxfull_q   <= rxfull_d;
            txdone_q   <= txdone_d;
            overrun_q  <= overrun_d;
            irq_q      <= irq_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
            rx_par_q   <= rx_par_d;
            perr_q     <= perr_d;
`endif
        end
    end

endmodule
